// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch / load-store memory arbiter.
// Provides the response owner tag and the default depth and starvation limit.
package mem_arbiter_pkg;

   typedef enum logic {
      OWNER_IF,
      OWNER_LS
   } mem_owner_e;

   localparam int MEM_ARB_MAX_OUTSTANDING = 2;
   localparam int MEM_ARB_STARVE_LIMIT    = 4;

endpackage

// File: rtl/mem_arbiter_owner_fifo.sv
// Circular owner FIFO: remembers who issued each outstanding bus request.
// Ports: clk, rst (sync, active-high), push/push_data, pop, head, full, empty.
module owner_fifo
   import mem_arbiter_pkg::*;
#(
   parameter int DEPTH = MEM_ARB_MAX_OUTSTANDING
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  mem_owner_e push_data,
   input  logic       pop,
   output mem_owner_e head,
   output logic       full,
   output logic       empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   mem_owner_e    slots [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign head    = slots[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            slots[wr_ptr] <= push_data;
            wr_ptr        <= bump(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= bump(rd_ptr);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (IF) and load/store (LS) onto one memory bus and
// routes in-order responses back. Ports: if_*, ls_*, bus_*, err_o.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = MEM_ARB_MAX_OUTSTANDING,
   parameter int STARVE_LIMIT    = MEM_ARB_STARVE_LIMIT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        ls_req_i,
   input  logic        ls_we_i,
   input  logic [31:0] ls_addr_i,
   input  logic [3:0]  ls_be_i,
   input  logic [31:0] ls_wdata_i,
   output logic        ls_gnt_o,
   output logic        ls_rvalid_o,
   output logic [31:0] ls_rdata_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   output logic        err_o
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   logic [SW-1:0] starve_cnt;
   logic          starved;
   logic          sel_if;
   logic          accept;
   logic          fifo_full;
   logic          fifo_empty;
   logic          resp_ok;
   mem_owner_e    head;

   // IF only beats a competing LS once it has waited long enough.
   assign starved = (starve_cnt >= LIMIT);
   assign sel_if  = if_req_i & (~ls_req_i | starved);

   assign bus_req_o = (if_req_i | ls_req_i) & ~fifo_full & ~rst_i;
   assign accept    = bus_req_o & bus_gnt_i;

   always_comb begin
      bus_we_o    = ls_we_i;
      bus_addr_o  = ls_addr_i;
      bus_be_o    = ls_be_i;
      bus_wdata_o = ls_wdata_i;
      if (sel_if) begin
         bus_we_o    = 1'b0;
         bus_addr_o  = if_addr_i;
         bus_be_o    = 4'hF;
         bus_wdata_o = '0;
      end
   end

   assign if_gnt_o = accept & sel_if;
   assign ls_gnt_o = accept & ~sel_if & ls_req_i;

   owner_fifo #(
      .DEPTH(MAX_OUTSTANDING)
   ) u_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .push     (accept),
      .push_data(sel_if ? OWNER_IF : OWNER_LS),
      .pop      (bus_rvalid_i),
      .head     (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Responses with nothing outstanding are dropped and flagged.
   assign resp_ok     = bus_rvalid_i & ~fifo_empty & ~rst_i;
   assign if_rvalid_o = resp_ok & (head == OWNER_IF);
   assign ls_rvalid_o = resp_ok & (head == OWNER_LS);
   assign if_rdata_o  = bus_rdata_i;
   assign ls_rdata_o  = bus_rdata_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt <= '0;
      end else if (!if_req_i || if_gnt_o) begin
         starve_cnt <= '0;
      end else if (!starved) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_o <= 1'b0;
      end else if (bus_rvalid_i && fifo_empty) begin
         err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random
// traffic, checked against a queue-based reference model.
module tb_mem_arbiter;

   localparam int MAXO = 2;
   localparam int LIM  = 4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        ls_req_i;
   logic        ls_we_i;
   logic [31:0] ls_addr_i;
   logic [3:0]  ls_be_i;
   logic [31:0] ls_wdata_i;
   logic        ls_gnt_o;
   logic        ls_rvalid_o;
   logic [31:0] ls_rdata_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic        bus_gnt_i;
   logic        bus_rvalid_i;
   logic [31:0] bus_rdata_i;
   logic        err_o;

   always #5 clk = ~clk;

   mem_arbiter #(
      .MAX_OUTSTANDING(MAXO),
      .STARVE_LIMIT   (LIM)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_gnt_o    (if_gnt_o),
      .if_rvalid_o (if_rvalid_o),
      .if_rdata_o  (if_rdata_o),
      .ls_req_i    (ls_req_i),
      .ls_we_i     (ls_we_i),
      .ls_addr_i   (ls_addr_i),
      .ls_be_i     (ls_be_i),
      .ls_wdata_i  (ls_wdata_i),
      .ls_gnt_o    (ls_gnt_o),
      .ls_rvalid_o (ls_rvalid_o),
      .ls_rdata_o  (ls_rdata_o),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_be_o    (bus_be_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_gnt_i   (bus_gnt_i),
      .bus_rvalid_i(bus_rvalid_i),
      .bus_rdata_i (bus_rdata_i),
      .err_o       (err_o)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: queue of owners (0 = IF, 1 = LS), IF wait count, error flag.
   bit q[$];
   int wait_m = 0;
   bit err_m  = 0;
   bit e_if_gnt;
   bit e_ls_gnt;

   // Observed values captured mid-cycle for directed checks.
   logic o_if_gnt, o_ls_gnt, o_if_rv, o_ls_rv, o_breq, o_we;
   logic [3:0]  o_be;
   logic [31:0] o_addr, o_if_rd, o_ls_rd;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst_i        = 1'b0;
      if_req_i     = 1'b0;
      if_addr_i    = '0;
      ls_req_i     = 1'b0;
      ls_we_i      = 1'b0;
      ls_addr_i    = '0;
      ls_be_i      = '0;
      ls_wdata_i   = '0;
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = '0;
   endtask

   task automatic tick();
      bit full_m;
      bit breq_m;
      bit ifw;
      bit rv_ok;
      @(negedge clk);
      full_m = (q.size() >= MAXO);
      breq_m = (if_req_i || ls_req_i) && !full_m && !rst_i;
      ifw    = if_req_i && (!ls_req_i || wait_m >= LIM);
      e_if_gnt = ifw && bus_gnt_i && breq_m;
      e_ls_gnt = ls_req_i && !ifw && bus_gnt_i && breq_m;
      rv_ok  = bus_rvalid_i && !rst_i && q.size() > 0;
      o_if_gnt = if_gnt_o;
      o_ls_gnt = ls_gnt_o;
      o_if_rv  = if_rvalid_o;
      o_ls_rv  = ls_rvalid_o;
      o_breq   = bus_req_o;
      o_we     = bus_we_o;
      o_be     = bus_be_o;
      o_addr   = bus_addr_o;
      o_if_rd  = if_rdata_o;
      o_ls_rd  = ls_rdata_o;
      chk("bus_req", bus_req_o, breq_m);
      chk("if_gnt", if_gnt_o, e_if_gnt);
      chk("ls_gnt", ls_gnt_o, e_ls_gnt);
      chk("if_rvalid", if_rvalid_o, rv_ok && q[0] == 1'b0);
      chk("ls_rvalid", ls_rvalid_o, rv_ok && q[0] == 1'b1);
      chk("err", err_o, err_m);
      chk("if_rdata", if_rdata_o, bus_rdata_i);
      chk("ls_rdata", ls_rdata_o, bus_rdata_i);
      if (breq_m) begin
         chk("bus_addr", bus_addr_o, ifw ? if_addr_i : ls_addr_i);
         chk("bus_we", bus_we_o, ifw ? 1'b0 : ls_we_i);
         chk("bus_be", bus_be_o, ifw ? 4'hF : ls_be_i);
         chk("bus_wdata", bus_wdata_o, ifw ? 32'h0 : ls_wdata_i);
      end
      @(posedge clk);
      if (rst_i) begin
         q.delete();
         wait_m = 0;
         err_m  = 0;
      end else begin
         if (bus_rvalid_i) begin
            if (q.size() == 0) err_m = 1;
            else void'(q.pop_front());
         end
         if (breq_m && bus_gnt_i) q.push_back(ifw ? 1'b0 : 1'b1);
         if (!if_req_i || e_if_gnt) wait_m = 0;
         else if (wait_m < LIM) wait_m++;
      end
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   bit if_hold;
   bit ls_hold;

   initial begin
      idle();
      @(posedge clk);
      #1;
      do_reset();
      tick();
      chk("rst_breq", o_breq, 1'b0);
      chk("rst_err", err_o, 1'b0);

      // Lone IF fetch, response next cycle.
      if_req_i  = 1'b1;
      if_addr_i = 32'h100;
      bus_gnt_i = 1'b1;
      tick();
      chk("lone_if_gnt", o_if_gnt, 1'b1);
      chk("lone_if_addr", o_addr, 32'h100);
      idle();
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'hDEADBEEF;
      tick();
      chk("lone_if_rv", o_if_rv, 1'b1);
      chk("lone_if_rd", o_if_rd, 32'hDEADBEEF);
      chk("lone_ls_rv", o_ls_rv, 1'b0);

      // Contention: LS write wins.
      idle();
      if_req_i   = 1'b1;
      if_addr_i  = 32'h104;
      ls_req_i   = 1'b1;
      ls_we_i    = 1'b1;
      ls_addr_i  = 32'h200;
      ls_be_i    = 4'b0011;
      ls_wdata_i = 32'hCAFE0001;
      bus_gnt_i  = 1'b1;
      tick();
      chk("cont_we", o_we, 1'b1);
      chk("cont_be", o_be, 4'h3);
      chk("cont_ls_gnt", o_ls_gnt, 1'b1);
      chk("cont_if_gnt", o_if_gnt, 1'b0);
      idle();
      bus_rvalid_i = 1'b1;
      tick();
      chk("cont_ls_rv", o_ls_rv, 1'b1);

      // Starvation override: IF gets through on its fifth cycle.
      do_reset();
      for (int c = 1; c <= LIM + 1; c++) begin
         if_req_i     = 1'b1;
         if_addr_i    = 32'h300;
         ls_req_i     = 1'b1;
         ls_we_i      = 1'b0;
         ls_addr_i    = 32'h400 + 32'(c);
         bus_gnt_i    = 1'b1;
         bus_rvalid_i = (c > 1);
         bus_rdata_i  = 32'(c);
         tick();
         chk("starve_if_gnt", o_if_gnt, c == LIM + 1);
         chk("starve_ls_gnt", o_ls_gnt, c <= LIM);
      end
      // Counter cleared: LS wins the next contention again.
      if_req_i  = 1'b1;
      if_addr_i = 32'h304;
      tick();
      chk("starve_clr", o_ls_gnt, 1'b1);
      idle();
      bus_rvalid_i = 1'b1;
      tick();

      // Full and in-order return.
      do_reset();
      if_req_i  = 1'b1;
      if_addr_i = 32'h500;
      bus_gnt_i = 1'b1;
      tick();
      idle();
      ls_req_i  = 1'b1;
      ls_addr_i = 32'h600;
      bus_gnt_i = 1'b1;
      tick();
      ls_addr_i = 32'h604;
      tick();
      chk("full_breq", o_breq, 1'b0);
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'h11;
      tick();
      chk("full_nobypass", o_breq, 1'b0);
      chk("order_if_rv", o_if_rv, 1'b1);
      chk("order_if_rd", o_if_rd, 32'h11);
      bus_rdata_i = 32'h22;
      tick();
      chk("order_ls_rv", o_ls_rv, 1'b1);
      chk("order_ls_rd", o_ls_rd, 32'h22);
      chk("reissue_breq", o_breq, 1'b1);
      idle();
      bus_rvalid_i = 1'b1;
      tick();
      bus_rvalid_i = 1'b1;
      tick();
      idle();

      // Stray response sets sticky error; reset clears it.
      bus_rvalid_i = 1'b1;
      tick();
      chk("stray_drop", o_if_rv | o_ls_rv, 1'b0);
      idle();
      tick();
      chk("err_set", err_o, 1'b1);
      if_req_i  = 1'b1;
      bus_gnt_i = 1'b1;
      tick();
      idle();
      tick();
      chk("err_sticky", err_o, 1'b1);
      rst_i        = 1'b1;
      if_req_i     = 1'b1;
      bus_gnt_i    = 1'b1;
      bus_rvalid_i = 1'b1;
      tick();
      chk("inrst_breq", o_breq, 1'b0);
      chk("inrst_gnt", o_if_gnt | o_ls_gnt, 1'b0);
      chk("inrst_rv", o_if_rv | o_ls_rv, 1'b0);
      idle();
      tick();
      chk("post_err", err_o, 1'b0);
      chk("post_breq", o_breq, 1'b0);
      chk("post_rv", o_if_rv | o_ls_rv, 1'b0);
      chk("post_gnt", o_if_gnt | o_ls_gnt, 1'b0);

      // Random traffic honouring the request-hold protocol.
      if_hold = 0;
      ls_hold = 0;
      for (int n = 0; n < 400; n++) begin
         rst_i = ($urandom_range(0, 99) == 0);
         if (!if_hold) begin
            if_req_i  = ($urandom_range(0, 2) != 0);
            if_addr_i = $urandom();
         end
         if (!ls_hold) begin
            ls_req_i   = ($urandom_range(0, 2) != 0);
            ls_we_i    = $urandom_range(0, 1);
            ls_addr_i  = $urandom();
            ls_be_i    = 4'($urandom());
            ls_wdata_i = $urandom();
         end
         bus_gnt_i    = ($urandom_range(0, 3) != 0);
         bus_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         bus_rdata_i  = $urandom();
         tick();
         if_hold = if_req_i && !e_if_gnt;
         ls_hold = ls_req_i && !e_ls_gnt;
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
